// File: rtl/square_root_iterative.sv
// Iterative restoring integer square root: one root bit per clock,
// with a start/busy/valid handshake and registered root and remainder.
module square_root_iterative #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   alpha,
  output logic               busy,
  output logic               valid,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   remainder
);

  localparam int N  = WIDTH / 2;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [N+1:0]     r_q, r_d;
  logic [N-1:0]     q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     root_q, root_d;
  logic [N:0]       rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;

  logic [N+1:0]     rShift, trial, rNext;
  logic [N-1:0]     qNext;

  // One restoring step; r never exceeds 2*q, so N+2 bits hold r<<2 without loss.
  always_comb begin
    rShift = (r_q << 2) | (N+2)'(opnd_q[WIDTH-1 -: 2]);
    trial  = ({2'b00, q_q} << 2) | (N+2)'(1);
    if (rShift >= trial) begin
      rNext = rShift - trial;
      qNext = (q_q << 1) | N'(1);
    end else begin
      rNext = rShift;
      qNext = q_q << 1;
    end
  end

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    root_d  = root_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          opnd_d  = alpha;
          r_d     = '0;
          q_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        opnd_d = opnd_q << 2;
        r_d    = rNext;
        q_d    = qNext;
        cnt_d  = cnt_q + CW'(1);
        // The final remainder is at most 2*root, so dropping the top bit is lossless.
        if (cnt_q == LAST) begin
          root_d  = qNext;
          rem_d   = rNext[N:0];
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      opnd_q  <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign root      = root_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_square_root_iterative.sv
// Directed bench for square_root_iterative: 8-bit and 16-bit instances sharing
// one clock and reset, table-driven vectors plus handshake corner sequences.
module tb_square_root_iterative;

  logic       clock;
  logic       reset;
  logic       start8, start16;
  logic [7:0] alpha8;
  logic [15:0] alpha16;
  logic       busy8, valid8, busy16, valid16;
  logic [3:0] root8;
  logic [4:0] rem8;
  logic [7:0] root16;
  logic [8:0] rem16;

  int numChecks = 0;
  int numFails  = 0;

  typedef struct {
    bit    wide;
    int    alpha;
    int    expRoot;
    int    expRem;
  } vec_t;

  square_root_iterative #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .alpha(alpha8),
    .busy(busy8), .valid(valid8), .root(root8), .remainder(rem8)
  );

  square_root_iterative #(.WIDTH(16)) dut16 (
    .clock(clock), .reset(reset), .start(start16), .alpha(alpha16),
    .busy(busy16), .valid(valid16), .root(root16), .remainder(rem16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference root found by plain upward search.
  function automatic int isqrt(input int a);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= a) r++;
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Launch one operation, then wait (bounded) for valid and check latency and results.
  task automatic applyStimulus(input bit wide, input int a, input int expRoot,
                               input int expRem, input string tag);
    int lat;
    bit seen;
    @(negedge clock);
    if (wide) begin start16 = 1'b1; alpha16 = 16'(a); end
    else      begin start8  = 1'b1; alpha8  = 8'(a);  end
    @(posedge clock); #1;
    checkOutput({tag, " busy"}, wide ? int'(busy16) : int'(busy8), 1);
    @(negedge clock);
    start8  = 1'b0;
    start16 = 1'b0;
    alpha8  = ~alpha8;
    alpha16 = ~alpha16;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clock); #1;
      lat++;
      seen = wide ? valid16 : valid8;
    end
    checkOutput({tag, " latency"}, lat, wide ? 8 : 4);
    checkOutput({tag, " root"}, wide ? int'(root16) : int'(root8), expRoot);
    checkOutput({tag, " remainder"}, wide ? int'(rem16) : int'(rem8), expRem);
  endtask

  initial begin
    vec_t vecs[$];
    bit   busyOk;
    bit   holdOk;
    int   extra;
    logic [9:0] vPat, bPat;
    int   r1, m1, r2, m2;

    reset = 1'b1; start8 = 1'b0; start16 = 1'b0; alpha8 = '0; alpha16 = '0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset busy8", busy8, 0);
    checkOutput("reset valid8", valid8, 0);
    checkOutput("reset root8", root8, 0);
    checkOutput("reset rem8", rem8, 0);
    checkOutput("reset busy16", busy16, 0);
    checkOutput("reset root16", root16, 0);
    checkOutput("reset rem16", rem16, 0);
    @(negedge clock);
    reset = 1'b0;

    vecs.push_back('{0, 0, 0, 0});
    vecs.push_back('{0, 144, 12, 0});
    vecs.push_back('{0, 200, 14, 4});
    vecs.push_back('{0, 255, 15, 30});
    vecs.push_back('{0, 1, 1, 0});
    vecs.push_back('{0, 3, 1, 2});
    vecs.push_back('{0, 15, 3, 6});
    vecs.push_back('{0, 16, 4, 0});
    vecs.push_back('{0, 99, 9, 18});
    vecs.push_back('{0, 225, 15, 0});
    vecs.push_back('{1, 65535, 255, 510});
    vecs.push_back('{1, 65024, 254, 508});
    vecs.push_back('{1, 1, 1, 0});
    vecs.push_back('{1, 0, 0, 0});
    vecs.push_back('{1, 40000, 200, 0});
    vecs.push_back('{1, 1000, 31, 39});

    foreach (vecs[i])
      applyStimulus(vecs[i].wide, vecs[i].alpha, vecs[i].expRoot, vecs[i].expRem,
                    $sformatf("vec%0d alpha=%0d", i, vecs[i].alpha));

    for (int a = 0; a < 256; a++) begin
      int r;
      r = isqrt(a);
      applyStimulus(1'b0, a, r, a - r * r, $sformatf("exh alpha=%0d", a));
    end

    // Start while busy: the second request must be dropped entirely.
    @(negedge clock);
    start8 = 1'b1; alpha8 = 8'd200;
    @(posedge clock); #1;
    busyOk = busy8;
    @(negedge clock);
    start8 = 1'b0;
    @(posedge clock); #1;
    busyOk &= busy8;
    @(negedge clock);
    start8 = 1'b1; alpha8 = 8'd9;
    @(posedge clock); #1;
    busyOk &= busy8;
    @(negedge clock);
    start8 = 1'b0;
    @(posedge clock); #1;
    busyOk &= busy8;
    @(posedge clock); #1;
    checkOutput("busy-start busy continuous", busyOk, 1);
    checkOutput("busy-start valid", valid8, 1);
    checkOutput("busy-start root", root8, 14);
    checkOutput("busy-start remainder", rem8, 4);
    extra = 0;
    repeat (10) begin
      @(posedge clock); #1;
      extra += int'(valid8);
    end
    checkOutput("busy-start extra valid", extra, 0);

    // Idle hold with alpha toggling.
    holdOk = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      alpha8 = 8'($urandom_range(0, 255));
      @(posedge clock); #1;
      if (valid8 !== 1'b0 || root8 !== 4'd14 || rem8 !== 5'd4) holdOk = 1'b0;
    end
    checkOutput("idle hold stable", holdOk, 1);

    // Back-to-back with start held high.
    @(negedge clock);
    start8 = 1'b1; alpha8 = 8'd144;
    r1 = -1; m1 = -1; r2 = -1; m2 = -1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      vPat[i] = valid8;
      bPat[i] = busy8;
      if (i == 0) alpha8 = 8'd255;
      if (i == 4) begin r1 = root8; m1 = rem8; end
      if (i == 9) begin r2 = root8; m2 = rem8; end
    end
    start8 = 1'b0;
    checkOutput("b2b valid pattern", vPat, 10'h210);
    checkOutput("b2b busy pattern", bPat, 10'h1EF);
    checkOutput("b2b root1", r1, 12);
    checkOutput("b2b rem1", m1, 0);
    checkOutput("b2b root2", r2, 15);
    checkOutput("b2b rem2", m2, 30);

    // Reset during the second RUN cycle.
    @(negedge clock);
    start8 = 1'b1; alpha8 = 8'd255;
    @(posedge clock); #1;
    start8 = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checkOutput("midreset busy", busy8, 0);
    checkOutput("midreset valid", valid8, 0);
    checkOutput("midreset root", root8, 0);
    checkOutput("midreset remainder", rem8, 0);
    extra = 0;
    repeat (8) begin
      @(posedge clock); #1;
      extra += int'(valid8);
    end
    checkOutput("midreset no valid", extra, 0);
    applyStimulus(1'b0, 49, 7, 0, "after reset alpha=49");

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
